manch_encoder: RTL and testbench

Serializes a parallel data word into a Manchester-coded bit stream for the `manch_decoder` receive stage, which consumes `datamout` on its `datamin` input. A word is accepted with a valid/ready handshake and shifted out MSB-first. Each bit occupies two half-bit periods of HALF_BIT_CYC clocks. The line is held at a defined idle level between frames.

---
 rtl/manch_encoder.sv | 119 +++++++++++
 tb/tb_manch_encoder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manch_encoder.sv
// Manchester (IEEE 802.3 convention) serializer, MSB-first, valid/ready input.
// Optional feature: define MANCH_PARITY_EN to append an even-parity bit
// after the LSB of every frame.
module manch_encoder #(
  parameter int   DATA_W       = 16,
  parameter int   HALF_BIT_CYC = 4,
  parameter logic IDLE_LEVEL   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              datamout,
  output logic              busy,
  output logic              frame_done
);

`ifdef MANCH_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam int HC_W  = ($clog2(HALF_BIT_CYC + 1) < 1) ? 1 : $clog2(HALF_BIT_CYC + 1);
  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HALF_BIT_CYC - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, FIRST_HALF, SECOND_HALF} state_t;

  state_t             state, state_n;
  logic [NBITS-1:0]   shreg, shreg_n;
  logic [CNT_W-1:0]   bitcnt, bitcnt_n;
  logic [HC_W-1:0]    halfcnt, halfcnt_n;
  logic [NBITS-1:0]   load_word;
  logic               datamout_n;
  logic               frame_done_n;

  // Parity rides as an extra LSB-side bit, so the shifter needs no special case.
`ifdef MANCH_PARITY_EN
  assign load_word = {din, ^din};
`else
  assign load_word = din;
`endif

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      halfcnt    <= '0;
      datamout   <= IDLE_LEVEL;
      busy       <= 1'b0;
      din_ready  <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bitcnt     <= bitcnt_n;
      halfcnt    <= halfcnt_n;
      datamout   <= datamout_n;
      busy       <= (state_n != IDLE);
      din_ready  <= (state_n == IDLE);
      frame_done <= frame_done_n;
    end
  end

  // Next-state logic; outputs are derived from the next state so they register
  // in step with it.
  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bitcnt_n     = bitcnt;
    halfcnt_n    = halfcnt;
    frame_done_n = 1'b0;
    case (state)
      IDLE: begin
        if (din_valid && din_ready) begin
          shreg_n   = load_word;
          bitcnt_n  = BIT_LAST;
          halfcnt_n = '0;
          state_n   = FIRST_HALF;
        end
      end
      FIRST_HALF: begin
        if (halfcnt == HC_LAST) begin
          halfcnt_n = '0;
          state_n   = SECOND_HALF;
        end else begin
          halfcnt_n = halfcnt + 1'b1;
        end
      end
      SECOND_HALF: begin
        if (halfcnt == HC_LAST) begin
          halfcnt_n = '0;
          if (bitcnt == '0) begin
            state_n      = IDLE;
            frame_done_n = 1'b1;
          end else begin
            shreg_n  = shreg << 1;
            bitcnt_n = bitcnt - 1'b1;
            state_n  = FIRST_HALF;
          end
        end else begin
          halfcnt_n = halfcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      FIRST_HALF:  datamout_n = ~shreg_n[NBITS-1];
      SECOND_HALF: datamout_n = shreg_n[NBITS-1];
      default:     datamout_n = IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_manch_encoder.sv
// Directed self-checking bench for manch_encoder (HALF_BIT_CYC=4 and =1).
module tb_manch_encoder;

`ifdef MANCH_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif
  localparam int NC  = 2 * NB * 4;
  localparam int NC1 = 2 * NB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready, datamout, busy, frame_done;
  logic [15:0] din1 = '0;
  logic        din_valid1 = 1'b0;
  logic        din_ready1, datamout1, busy1, frame_done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  manch_encoder #(.DATA_W(16), .HALF_BIT_CYC(4), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .datamout(datamout), .busy(busy), .frame_done(frame_done)
  );

  manch_encoder #(.DATA_W(16), .HALF_BIT_CYC(1), .IDLE_LEVEL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid1),
    .din_ready(din_ready1), .datamout(datamout1), .busy(busy1), .frame_done(frame_done1)
  );

  // Transmitted bit sequence (MSB first, optional even parity appended).
  function automatic logic [16:0] wordof(input logic [15:0] d);
`ifdef MANCH_PARITY_EN
    return {d, ^d};
`else
    return {1'b0, d};
`endif
  endfunction

  // Expected line level at coded cycle k: first half ~bit, second half bit.
  function automatic logic exp_level(input logic [16:0] w, input int k, input int hb);
    int   idx;
    logic b;
    idx = k / (2 * hb);
    b   = w[NB-1-idx];
    return (((k / hb) % 2) == 1) ? b : ~b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 16'hBEEF; din_valid = 1'b1;
    din1 = 16'hBEEF; din_valid1 = 1'b1;
    tick(); tick();
    checks++;
    if (datamout !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got dm=%b busy=%b fd=%b rdy=%b want 0 0 0 1",
               datamout, busy, frame_done, din_ready);
    end
    checks++;
    if (busy1 !== 1'b0 || din_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_state_hb1 got busy=%b rdy=%b want 0 1", busy1, din_ready1);
    end
    rst = 1'b0; din_valid = 1'b0; din_valid1 = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || datamout !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins got busy=%b dm=%b want 0 0", busy, datamout);
    end
  endtask

  task automatic test_single();
    logic [16:0] w;
    w = wordof(16'h6CA5);
    din = 16'h6CA5; din_valid = 1'b1;
    for (int k = 0; k < NC; k++) begin
      tick();
      if (k == 0) begin din_valid = 1'b0; din = 16'h0000; end
      checks++;
      if (datamout !== exp_level(w, k, 4) || busy !== 1'b1 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL single_frame cyc %0d got dm=%b busy=%b fd=%b want dm=%b busy=1 fd=0",
                 k, datamout, busy, frame_done, exp_level(w, k, 4));
      end
    end
    tick();
    checks++;
    if (frame_done !== 1'b1 || datamout !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_done got fd=%b dm=%b busy=%b rdy=%b want 1 0 0 1",
               frame_done, datamout, busy, din_ready);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse got fd=%b want 0", frame_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] wa, wb;
    wa = wordof(16'hFFFF);
    wb = wordof(16'h0000);
    din = 16'hFFFF; din_valid = 1'b1;
    for (int k = 0; k < NC; k++) begin
      tick();
      if (k == 0) din = 16'h0000;
      checks++;
      if (datamout !== exp_level(wa, k, 4) || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_first cyc %0d got dm=%b busy=%b want dm=%b busy=1",
                 k, datamout, busy, exp_level(wa, k, 4));
      end
    end
    tick();
    checks++;
    if (frame_done !== 1'b1 || din_ready !== 1'b1 || datamout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got fd=%b rdy=%b dm=%b busy=%b want 1 1 0 0",
               frame_done, din_ready, datamout, busy);
    end
    for (int k = 0; k < NC; k++) begin
      tick();
      if (k == 0) din_valid = 1'b0;
      checks++;
      if (datamout !== exp_level(wb, k, 4) || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_second cyc %0d got dm=%b busy=%b want dm=%b busy=1",
                 k, datamout, busy, exp_level(wb, k, 4));
      end
    end
    tick();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done got fd=%b want 1", frame_done);
    end
  endtask

  task automatic test_ignore_busy();
    logic [16:0] w;
    w = wordof(16'hA5C3);
    din = 16'hA5C3; din_valid = 1'b1;
    for (int k = 0; k < NC; k++) begin
      tick();
      if (k == 0)  din_valid = 1'b0;
      if (k == 20) begin din = 16'hFFFF; din_valid = 1'b1; end
      if (k == 24) din_valid = 1'b0;
      checks++;
      if (datamout !== exp_level(w, k, 4) || din_ready !== 1'b0) begin
        errors++;
        $display("FAIL ignore_busy cyc %0d got dm=%b rdy=%b want dm=%b rdy=0",
                 k, datamout, din_ready, exp_level(w, k, 4));
      end
    end
    tick();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy_done got fd=%b want 1", frame_done);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || datamout !== 1'b0) begin
        errors++;
        $display("FAIL ignore_busy_extra cyc %0d got busy=%b dm=%b want 0 0", k, busy, datamout);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [16:0] w;
    w = wordof(16'h1234);
    din = 16'h1234; din_valid = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      tick();
      if (k == 0) din_valid = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (datamout !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset got dm=%b busy=%b rdy=%b fd=%b want 0 0 1 0",
               datamout, busy, din_ready, frame_done);
    end
    for (int k = 0; k < NC; k++) begin
      tick();
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet cyc %0d got fd=%b busy=%b want 0 0", k, frame_done, busy);
      end
    end
    w = wordof(16'h0F0F);
    din = 16'h0F0F; din_valid = 1'b1;
    for (int k = 0; k < NC; k++) begin
      tick();
      if (k == 0) din_valid = 1'b0;
      checks++;
      if (datamout !== exp_level(w, k, 4)) begin
        errors++;
        $display("FAIL midreset_next cyc %0d got dm=%b want %b", k, datamout, exp_level(w, k, 4));
      end
    end
    tick();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL midreset_next_done got fd=%b want 1", frame_done);
    end
  endtask

  task automatic test_hb1();
    logic [16:0] w;
    w = wordof(16'h8001);
    din1 = 16'h8001; din_valid1 = 1'b1;
    for (int k = 0; k < NC1; k++) begin
      tick();
      if (k == 0) din_valid1 = 1'b0;
      checks++;
      if (datamout1 !== exp_level(w, k, 1) || busy1 !== 1'b1) begin
        errors++;
        $display("FAIL hb1_frame cyc %0d got dm=%b busy=%b want dm=%b busy=1",
                 k, datamout1, busy1, exp_level(w, k, 1));
      end
      // MSB=1 encodes as 0 then 1
      if (k < 2) begin
        checks++;
        if (datamout1 !== ((k == 0) ? 1'b0 : 1'b1)) begin
          errors++;
          $display("FAIL hb1_msb cyc %0d got dm=%b", k, datamout1);
        end
      end
    end
    tick();
    checks++;
    if (frame_done1 !== 1'b1 || datamout1 !== 1'b0) begin
      errors++;
      $display("FAIL hb1_done got fd=%b dm=%b want 1 0", frame_done1, datamout1);
    end
  endtask

`ifdef MANCH_PARITY_EN
  task automatic test_parity();
    logic [16:0] w;
    w = wordof(16'h0007);
    din = 16'h0007; din_valid = 1'b1;
    for (int k = 0; k < NC; k++) begin
      tick();
      if (k == 0) din_valid = 1'b0;
      checks++;
      if (datamout !== exp_level(w, k, 4)) begin
        errors++;
        $display("FAIL parity_frame cyc %0d got dm=%b want %b", k, datamout, exp_level(w, k, 4));
      end
      // parity of 0x0007 is 1: L x4 then H x4 in the last bit slot
      if (k >= 128) begin
        checks++;
        if (datamout !== ((k < 132) ? 1'b0 : 1'b1)) begin
          errors++;
          $display("FAIL parity_bit cyc %0d got dm=%b", k, datamout);
        end
      end
    end
    tick();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL parity_done got fd=%b want 1", frame_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    tick();
    test_back_to_back();
    tick();
    test_ignore_busy();
    test_reset_midframe();
    tick();
    test_hb1();
`ifdef MANCH_PARITY_EN
    tick();
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
